eth_tx_sched: RTL
=================

# eth_tx_sched

Transmit scheduler placed in front of the Ethernet MAC transmit port. It arbitrates round-robin between two frame sources (ch0: acquisition data, ch1: command replies), builds the destination MAC, source MAC and EtherType header, streams the granted channel's payload, and zero-pads short frames. It also drives the MAC's trigger, data and last-byte handshake and enforces an inter-frame gap. The MAC appends the FCS; preamble and SFD are not generated here.

## Interface
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination address, sent MSB byte first
- SRC_MAC, 48'h0010_2030_4050, source address, sent MSB byte first
- ETYPE0, 16'h88B5, EtherType for ch0 frames
- ETYPE1, 16'h88B6, EtherType for ch1 frames
- IFG_CYCLES, 12, idle cycles after each frame (range 2..255)
- i_clk  in  1  single clock for the whole block
- i_rst_n  in  1  asynchronous, active-low reset
- i_chN_req  in  1  (N=0,1) frame request, level
- i_chN_len  in  11  payload byte count, sampled at grant
- i_chN_data  in  8  show-ahead payload byte; valid whenever the source holds a request
- o_chN_rd  out  1  consume strobe; the source advances to the next byte after the cycle
- o_chN_done  out  1  one-cycle pulse when the frame is finished on the wire
- o_mac_trig  out  1  to MAC i_tx_trig
- o_mac_data  out  8  to MAC i_data, registered
- o_mac_last  out  1  to MAC i_last_data, registered
- i_mac_tx_over  in  1  from MAC o_tx_over
- o_busy  out  1  high from grant until IFG expiry
- o_frame_cnt  out  16  completed-frame count, wraps

## Operation
- Reset values: all outputs are 0, the round-robin pointer favours ch0, and the state is IDLE.
- States:
  - IDLE: on any request, grant a channel, latch its length L and EtherType, and go to HDR.
  - HDR: send 14 bytes, then go to PAYLOAD, or to PAD if the clamped L is 0.
  - PAYLOAD: send L bytes, then go to PAD if L < 46, otherwise to WAIT.
  - PAD: send 46 − L bytes of 8'h00, then go to WAIT.
  - WAIT: on i_mac_tx_over, go to IFG.
  - IFG: count IFG_CYCLES cycles, then go to IDLE.
- Header byte order: DST_MAC[47:40] … DST_MAC[7:0], SRC_MAC[47:40] … SRC_MAC[7:0], ETYPE[15:8], ETYPE[7:0].
- Length rules:
  - L is clamped to 1500 when i_chN_len > 1500; only 1500 bytes are read.
  - L = 0 is legal; no reads occur and the payload is 46 bytes of pad.
  - Frame byte count N = 14 + max(L, 46), range 60..1514.
- Arbitration:
  - If only one channel requests, that channel is granted.
  - If both request, the channel that was not granted last is granted.
  - The pointer updates at grant.
- Requests are sampled only in IDLE. Dropping a request after grant does not abort the frame. The source must keep supplying bytes.
- o_chN_rd is asserted only for the granted channel and only for payload bytes: exactly L pulses per frame.
- o_mac_trig is held high from the first trig cycle until i_mac_tx_over is sampled high, then drops. IFG_CYCLES ≥ 2 guarantees the MAC sees a fresh rising edge for the next frame.
- o_chN_done and the o_frame_cnt increment occur in the cycle after i_mac_tx_over is sampled.
- An asynchronous reset at any point returns everything to reset values immediately. No done pulse is issued for the aborted frame.

## Timing
- Let T be the IDLE cycle in which a request is sampled.
  - T+1: o_mac_trig rises and o_busy rises.
  - T+2+k: frame byte k is on o_mac_data, for k = 0..N−1.
  - T+1+N: o_mac_last is high for exactly one cycle, coincident with byte N−1.
- Payload byte j appears at T+16+j. Its o_chN_rd pulse is in cycle T+15+j, so i_chN_data is captured at the end of that cycle.
- After the last byte, o_mac_data is don't-care and o_mac_last is 0.
- WAIT has no timeout: the MAC always completes.
- Let R be the cycle in which i_mac_tx_over is sampled high.
  - R+1: o_mac_trig = 0 and the done pulse fires.
  - R+1 … R+IFG_CYCLES: IFG.
  - R+IFG_CYCLES+1: IDLE, where requests are sampled again and o_busy = 0.

## Test plan
- ch0 only, len = 100: trig at T+1; bytes FF×6, 00 10 20 30 40 50, 88 B5 at T+2..T+15; 100 rd pulses; last at T+115; one ch0 done; o_frame_cnt = 1.
- ch1, len = 10: 10 payload bytes followed by 36 bytes of 00; N = 60; last at T+61; exactly 10 rd pulses.
- ch0 len = 0 and ch1 len = 2000 requested together from reset: ch0 is served first (60-byte frame, no reads); ch1 follows with 1500 reads and N = 1514.
- Both channels requesting continuously for 4 frames: grants alternate 0, 1, 0, 1; trig is low for IFG_CYCLES+1 cycles between frames.
- i_mac_tx_over delayed 20 cycles after last: trig stays high and o_busy stays high throughout; done occurs one cycle after tx_over is sampled.
- i_rst_n pulsed low mid-payload: all outputs are 0 asynchronously; no done pulse; o_frame_cnt = 0; the next request restarts cleanly with ch0 priority.

Source files
------------

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: two-source round-robin transmit scheduler feeding the MAC
// transmit port. Builds the 14-byte Ethernet header, streams the granted
// channel's payload, zero-pads to the 60-byte minimum, then holds the MAC
// trigger until the MAC reports completion and enforces an inter-frame gap.
module eth_tx_sched #(
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h0010_2030_4050,
  parameter logic [15:0] ETYPE0     = 16'h88B5,
  parameter logic [15:0] ETYPE1     = 16'h88B6,
  parameter int          IFG_CYCLES = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ch0_req,
  input  logic [10:0] i_ch0_len,
  input  logic [7:0]  i_ch0_data,
  output logic        o_ch0_rd,
  output logic        o_ch0_done,
  input  logic        i_ch1_req,
  input  logic [10:0] i_ch1_len,
  input  logic [7:0]  i_ch1_data,
  output logic        o_ch1_rd,
  output logic        o_ch1_done,
  output logic        o_mac_trig,
  output logic [7:0]  o_mac_data,
  output logic        o_mac_last,
  input  logic        i_mac_tx_over,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PAD     = 3'd3,
    S_WAIT    = 3'd4,
    S_IFG     = 3'd5
  } state_t;

  state_t      state;
  logic [10:0] cnt;        // byte index within the current section, or IFG count
  logic [10:0] len;        // clamped payload length of the frame in flight
  logic [15:0] etype;      // EtherType of the frame in flight
  logic        gnt;        // channel currently granted
  logic        ptr;        // channel favoured when both request
  logic        sel;
  logic [10:0] sel_len;
  logic [10:0] clamp_len;

  // Header byte for position idx (0..13): destination, source, EtherType.
  function automatic logic [7:0] hdr_byte(input logic [10:0] idx, input logic [15:0] et);
    logic [7:0] b;
    case (idx)
      11'd0:   b = DST_MAC[47:40];
      11'd1:   b = DST_MAC[39:32];
      11'd2:   b = DST_MAC[31:24];
      11'd3:   b = DST_MAC[23:16];
      11'd4:   b = DST_MAC[15:8];
      11'd5:   b = DST_MAC[7:0];
      11'd6:   b = SRC_MAC[47:40];
      11'd7:   b = SRC_MAC[39:32];
      11'd8:   b = SRC_MAC[31:24];
      11'd9:   b = SRC_MAC[23:16];
      11'd10:  b = SRC_MAC[15:8];
      11'd11:  b = SRC_MAC[7:0];
      11'd12:  b = et[15:8];
      11'd13:  b = et[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Round-robin choice between requesters and payload length clamp to 1500.
  always_comb begin
    sel = 1'b0;
    if (i_ch0_req && i_ch1_req) begin
      sel = ptr;
    end else if (i_ch1_req) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    sel_len = sel ? i_ch1_len : i_ch0_len;
    if (sel_len > 11'd1500) begin
      clamp_len = 11'd1500;
    end else begin
      clamp_len = sel_len;
    end
  end

  // Frame FSM; every output is registered here so the MAC sees clean levels.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      cnt         <= 11'd0;
      len         <= 11'd0;
      etype       <= 16'h0000;
      gnt         <= 1'b0;
      ptr         <= 1'b0;
      o_ch0_rd    <= 1'b0;
      o_ch1_rd    <= 1'b0;
      o_ch0_done  <= 1'b0;
      o_ch1_done  <= 1'b0;
      o_mac_trig  <= 1'b0;
      o_mac_data  <= 8'h00;
      o_mac_last  <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_cnt <= 16'd0;
    end else begin
      o_ch0_rd   <= 1'b0;
      o_ch1_rd   <= 1'b0;
      o_ch0_done <= 1'b0;
      o_ch1_done <= 1'b0;
      o_mac_last <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_ch0_req || i_ch1_req) begin
            gnt        <= sel;
            ptr        <= ~sel;
            len        <= clamp_len;
            etype      <= sel ? ETYPE1 : ETYPE0;
            cnt        <= 11'd0;
            o_mac_trig <= 1'b1;
            o_busy     <= 1'b1;
            state      <= S_HDR;
          end
        end
        S_HDR: begin
          o_mac_data <= hdr_byte(cnt, etype);
          if (cnt == 11'd13) begin
            cnt <= 11'd0;
            if (len == 11'd0) begin
              state <= S_PAD;
            end else begin
              // rd is registered, so it is raised one cycle ahead of the capture.
              o_ch0_rd <= ~gnt;
              o_ch1_rd <= gnt;
              state    <= S_PAYLOAD;
            end
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        S_PAYLOAD: begin
          o_mac_data <= gnt ? i_ch1_data : i_ch0_data;
          if (cnt == len - 11'd1) begin
            // cnt continues from L so PAD can stop at the fixed index 45.
            cnt <= cnt + 11'd1;
            if (len < 11'd46) begin
              state <= S_PAD;
            end else begin
              o_mac_last <= 1'b1;
              state      <= S_WAIT;
            end
          end else begin
            cnt      <= cnt + 11'd1;
            o_ch0_rd <= ~gnt;
            o_ch1_rd <= gnt;
          end
        end
        S_PAD: begin
          o_mac_data <= 8'h00;
          if (cnt == 11'd45) begin
            o_mac_last <= 1'b1;
            state      <= S_WAIT;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        S_WAIT: begin
          if (i_mac_tx_over) begin
            o_mac_trig  <= 1'b0;
            o_ch0_done  <= ~gnt;
            o_ch1_done  <= gnt;
            o_frame_cnt <= o_frame_cnt + 16'd1;
            cnt         <= 11'd0;
            state       <= S_IFG;
          end
        end
        S_IFG: begin
          if (cnt == 11'(IFG_CYCLES - 1)) begin
            o_busy <= 1'b0;
            cnt    <= 11'd0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
